// File: rtl/gfx_fb_write_arb.sv
// ---------------------------------------------------------------------------
// gfx_fb_write_arb
//
// Multi-channel pixel write front end for the frame buffer. NUM_CH gfx
// producers offer (x, y, color) pixels; a round-robin arbiter accepts one at
// a time. Each accepted pixel is clipped against the frame buffer bounds,
// turned into a linear address and issued as a single AXI write (aw/w/b).
// Only one AXI transaction is ever outstanding, so writes land in accept order.
//
// Ports
//   axi_clk, axi_resetn      single clock, asynchronous active-low reset
//   gfx_x/gfx_y/gfx_color    per-channel pixel, channel i at [i*W +: W]
//   gfx_valid / gfx_ready    per-channel handshake (ready is one-hot or zero)
//   axi_aw* / axi_w* / axi_b* AXI write channels towards the SRAM controller
//   busy                     high whenever the FSM is not IDLE
//   dropped_count            saturating count of clipped pixels
//   wr_err                   sticky: some write response was not OKAY
// ---------------------------------------------------------------------------
module gfx_fb_write_arb #(
    parameter int NUM_CH         = 2,
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int FB_BASE        = 0,
    parameter int PIXEL_BITS     = 12,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16,
    localparam int X_BITS        = $clog2(FB_WIDTH),
    localparam int Y_BITS        = $clog2(FB_HEIGHT),
    localparam int CH_BITS       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int STRB_BITS     = (AXI_DATA_WIDTH + 7) / 8
) (
    input  logic                           axi_clk,
    input  logic                           axi_resetn,
    input  logic [NUM_CH*X_BITS-1:0]       gfx_x,
    input  logic [NUM_CH*Y_BITS-1:0]       gfx_y,
    input  logic [NUM_CH*PIXEL_BITS-1:0]   gfx_color,
    input  logic [NUM_CH-1:0]              gfx_valid,
    output logic [NUM_CH-1:0]              gfx_ready,
    output logic [AXI_ADDR_WIDTH-1:0]      axi_awaddr,
    output logic                           axi_awvalid,
    input  logic                           axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]      axi_wdata,
    output logic [STRB_BITS-1:0]           axi_wstrb,
    output logic                           axi_wvalid,
    input  logic                           axi_wready,
    input  logic                           axi_bvalid,
    output logic                           axi_bready,
    input  logic [1:0]                     axi_bresp,
    output logic                           busy,
    output logic [15:0]                    dropped_count,
    output logic                           wr_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                      r_state;
    state_t                      w_next_state;

    logic [CH_BITS-1:0]          r_rr_ptr;
    logic [X_BITS-1:0]           r_x;
    logic [Y_BITS-1:0]           r_y;
    logic [PIXEL_BITS-1:0]       r_color;
    logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
    logic [AXI_DATA_WIDTH-1:0]   r_wdata;
    logic                        r_awvalid;
    logic                        r_wvalid;
    logic [15:0]                 r_dropped_count;
    logic                        r_wr_err;

    logic [X_BITS-1:0]           w_x_arr     [NUM_CH];
    logic [Y_BITS-1:0]           w_y_arr     [NUM_CH];
    logic [PIXEL_BITS-1:0]       w_color_arr [NUM_CH];
    logic [CH_BITS:0]            w_pick;
    logic                        w_grant_found;
    logic [CH_BITS-1:0]          w_grant;
    logic                        w_clip;
    logic                        w_aw_done;
    logic                        w_w_done;

    // Unpack the per-channel buses so the grant can select a whole pixel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_x_arr[g]     = gfx_x[g*X_BITS +: X_BITS];
        assign w_y_arr[g]     = gfx_y[g*Y_BITS +: Y_BITS];
        assign w_color_arr[g] = gfx_color[g*PIXEL_BITS +: PIXEL_BITS];
    end

    // Round-robin search starting at ptr. Result MSB = found, low bits = channel.
    function automatic logic [CH_BITS:0] rr_pick(input logic [NUM_CH-1:0] valid,
                                                 input logic [CH_BITS-1:0] ptr);
        logic [CH_BITS:0] res;
        int               idx;
        res = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!res[CH_BITS] && valid[CH_BITS'(idx)]) res = {1'b1, CH_BITS'(idx)};
        end
        return res;
    endfunction

    assign w_pick        = rr_pick(gfx_valid, r_rr_ptr);
    assign w_grant_found = w_pick[CH_BITS];
    assign w_grant       = w_pick[CH_BITS-1:0];

    assign w_clip    = (32'(r_x) >= 32'(FB_WIDTH)) || (32'(r_y) >= 32'(FB_HEIGHT));
    // A channel counts as done once its valid has dropped or is handshaking now.
    assign w_aw_done = !r_awvalid || axi_awready;
    assign w_w_done  = !r_wvalid  || axi_wready;

    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) r_state <= IDLE;
        else             r_state <= w_next_state;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        gfx_ready    = '0;
        axi_bready   = 1'b0;
        busy         = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                // Ready is also gated by reset: the FSM sits in IDLE during
                // reset, but nothing may be accepted then.
                if (w_grant_found && axi_resetn) gfx_ready[w_grant] = 1'b1;
                if (w_grant_found)               w_next_state = CALC;
            end
            CALC:  w_next_state = w_clip ? IDLE : WRITE;
            WRITE: if (w_aw_done && w_w_done) w_next_state = RESP;
            RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge axi_clk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rr_ptr        <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_color         <= '0;
            r_awaddr        <= '0;
            r_wdata         <= '0;
            r_awvalid       <= 1'b0;
            r_wvalid        <= 1'b0;
            r_dropped_count <= '0;
            r_wr_err        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_grant_found) begin
                        r_x      <= w_x_arr[w_grant];
                        r_y      <= w_y_arr[w_grant];
                        r_color  <= w_color_arr[w_grant];
                        r_rr_ptr <= (w_grant == CH_BITS'(NUM_CH - 1)) ? '0 : w_grant + 1'b1;
                    end
                end
                CALC: begin
                    if (w_clip) begin
                        if (r_dropped_count != 16'hFFFF) r_dropped_count <= r_dropped_count + 16'd1;
                    end else begin
                        // Full-precision linear address, truncated to the bus.
                        r_awaddr  <= AXI_ADDR_WIDTH'(64'(FB_BASE) + 64'(r_y) * 64'(FB_WIDTH) + 64'(r_x));
                        r_wdata   <= AXI_DATA_WIDTH'(r_color);
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (axi_awready) r_awvalid <= 1'b0;
                    if (axi_wready)  r_wvalid  <= 1'b0;
                end
                RESP: begin
                    if (axi_bvalid && (axi_bresp != 2'b00)) r_wr_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign axi_awaddr    = r_awaddr;
    assign axi_awvalid   = r_awvalid;
    assign axi_wdata     = r_wdata;
    assign axi_wvalid    = r_wvalid;
    // Full-pixel writes only, so the strobe never changes.
    assign axi_wstrb     = '1;
    assign dropped_count = r_dropped_count;
    assign wr_err        = r_wr_err;

endmodule

// File: tb/tb_gfx_fb_write_arb.sv
// ---------------------------------------------------------------------------
// tb_gfx_fb_write_arb
//
// Directed bench for gfx_fb_write_arb with three producer channels, a 640x480
// frame buffer at base 0x1000 and a simple AXI write slave whose awready and
// wready are steered by the scenarios. Expected values are hand computed.
// ---------------------------------------------------------------------------
module tb_gfx_fb_write_arb;

    localparam int NUM_CH  = 3;
    localparam int X_BITS  = 10;
    localparam int Y_BITS  = 9;
    localparam int PBITS   = 12;
    localparam int FB_BASE = 32'h1000;

    logic                      axi_clk;
    logic                      axi_resetn;
    logic [NUM_CH*X_BITS-1:0]  gfx_x;
    logic [NUM_CH*Y_BITS-1:0]  gfx_y;
    logic [NUM_CH*PBITS-1:0]   gfx_color;
    logic [NUM_CH-1:0]         gfx_valid;
    logic [NUM_CH-1:0]         gfx_ready;
    logic [19:0]               axi_awaddr;
    logic                      axi_awvalid;
    logic                      axi_awready;
    logic [15:0]               axi_wdata;
    logic [1:0]                axi_wstrb;
    logic                      axi_wvalid;
    logic                      axi_wready;
    logic                      axi_bvalid;
    logic                      axi_bready;
    logic [1:0]                axi_bresp;
    logic                      busy;
    logic [15:0]               dropped_count;
    logic                      wr_err;

    int          checks = 0;
    int          errors = 0;
    int          grant_log [$];
    logic [19:0] aw_log [$];
    logic [15:0] w_log [$];
    int          multi_ready = 0;
    int          awvalid_cycles = 0;
    logic [1:0]  slave_bresp = 2'b00;

    gfx_fb_write_arb #(
        .NUM_CH(NUM_CH), .FB_WIDTH(640), .FB_HEIGHT(480), .FB_BASE(FB_BASE),
        .PIXEL_BITS(PBITS), .AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(16)
    ) dut (
        .axi_clk(axi_clk), .axi_resetn(axi_resetn),
        .gfx_x(gfx_x), .gfx_y(gfx_y), .gfx_color(gfx_color),
        .gfx_valid(gfx_valid), .gfx_ready(gfx_ready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_bresp(axi_bresp), .busy(busy), .dropped_count(dropped_count), .wr_err(wr_err)
    );

    initial begin
        axi_clk = 1'b0;
        forever #5 axi_clk = ~axi_clk;
    end

    // Monitor: accepts, ready exclusivity, awvalid activity (pre-edge values).
    initial begin
        forever begin
            @(posedge axi_clk);
            if (axi_resetn) begin
                for (int c = 0; c < NUM_CH; c++)
                    if (gfx_valid[c] && gfx_ready[c]) grant_log.push_back(c);
                if ($countones(gfx_ready) > 1) multi_ready++;
                if (axi_awvalid) awvalid_cycles++;
            end
        end
    end

    // AXI write slave: logs handshakes, returns bvalid the cycle after both
    // aw and w have completed, holds it until bready.
    initial begin
        automatic bit aw_seen = 0;
        automatic bit w_seen  = 0;
        automatic bit b_hs    = 0;
        axi_bvalid = 1'b0;
        axi_bresp  = 2'b00;
        forever begin
            @(posedge axi_clk);
            if (!axi_resetn) begin
                aw_seen = 0; w_seen = 0; axi_bvalid = 1'b0;
            end else begin
                if (axi_awvalid && axi_awready) begin aw_seen = 1; aw_log.push_back(axi_awaddr); end
                if (axi_wvalid && axi_wready)   begin w_seen = 1;  w_log.push_back(axi_wdata);   end
                b_hs = axi_bvalid && axi_bready;
                @(negedge axi_clk);
                if (b_hs) axi_bvalid = 1'b0;
                if (aw_seen && w_seen && !axi_bvalid) begin
                    axi_bvalid = 1'b1; axi_bresp = slave_bresp; aw_seen = 0; w_seen = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_pix(input int ch, input int x, input int y, input int color);
        gfx_x[ch*X_BITS +: X_BITS]    = X_BITS'(x);
        gfx_y[ch*Y_BITS +: Y_BITS]    = Y_BITS'(y);
        gfx_color[ch*PBITS +: PBITS]  = PBITS'(color);
    endtask

    task automatic do_reset();
        @(negedge axi_clk);
        axi_resetn = 1'b0;
        repeat (2) @(negedge axi_clk);
        axi_resetn = 1'b1;
    endtask

    // Offer one pixel on ch and hold it until accepted. Returns at the
    // falling edge of the cycle after the accept (the CALC cycle).
    task automatic send_pixel(input int ch, input int x, input int y, input int color);
        automatic bit got = 0;
        @(negedge axi_clk);
        set_pix(ch, x, y, color);
        gfx_valid[ch] = 1'b1;
        for (int n = 0; n < 100 && !got; n++) begin
            #1;
            if (gfx_ready[ch]) got = 1;
            else @(negedge axi_clk);
        end
        if (got) @(negedge axi_clk);
        gfx_valid[ch] = 1'b0;
        checks++;
        if (!got) begin errors++; $display("FAIL send_pixel_accept ch%0d: ready never seen within 100 cycles", ch); end
    endtask

    task automatic wait_idle();
        automatic int n = 0;
        @(negedge axi_clk); #1;
        while (busy && n < 100) begin @(negedge axi_clk); #1; n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle: busy=%b still after 100 cycles", busy); end
    endtask

    task automatic test_reset();
        axi_resetn  = 1'b0;
        axi_awready = 1'b1;
        axi_wready  = 1'b1;
        gfx_x = '0; gfx_y = '0; gfx_color = '0;
        gfx_valid   = 3'b111;
        #12;
        checks += 9;
        if (gfx_ready !== 3'b000)      begin errors++; $display("FAIL reset_ready: got %b want 000", gfx_ready); end
        if (axi_awvalid !== 1'b0)      begin errors++; $display("FAIL reset_awvalid: got %b want 0", axi_awvalid); end
        if (axi_wvalid !== 1'b0)       begin errors++; $display("FAIL reset_wvalid: got %b want 0", axi_wvalid); end
        if (axi_bready !== 1'b0)       begin errors++; $display("FAIL reset_bready: got %b want 0", axi_bready); end
        if (busy !== 1'b0)             begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (axi_awaddr !== 20'h0 || axi_wdata !== 16'h0)
                                       begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", axi_awaddr, axi_wdata); end
        if (axi_wstrb !== 2'b11)       begin errors++; $display("FAIL reset_wstrb: got %b want 11", axi_wstrb); end
        if (dropped_count !== 16'h0)   begin errors++; $display("FAIL reset_dropped: got %h want 0", dropped_count); end
        if (wr_err !== 1'b0)           begin errors++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
        gfx_valid = 3'b000;
        @(negedge axi_clk);
        axi_resetn = 1'b1;
    endtask

    task automatic test_single_write();
        aw_log.delete(); w_log.delete();
        @(negedge axi_clk);
        set_pix(0, 5, 2, 12'hABC);
        gfx_valid = 3'b001;
        #1; checks++;
        if (gfx_ready !== 3'b001) begin errors++; $display("FAIL single_ready_T: got %b want 001", gfx_ready); end
        @(negedge axi_clk); gfx_valid = 3'b000; #1;                          // T+1 CALC
        checks += 2;
        if (busy !== 1'b1)        begin errors++; $display("FAIL single_busy_calc: got %b want 1", busy); end
        if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL single_awvalid_calc: got %b want 0", axi_awvalid); end
        @(negedge axi_clk); #1;                                              // T+2 WRITE
        checks += 3;
        if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1)
                                  begin errors++; $display("FAIL single_valids_T2: got aw=%b w=%b want 1/1", axi_awvalid, axi_wvalid); end
        if (axi_awaddr !== 20'h01505) begin errors++; $display("FAIL single_awaddr: got %h want 01505", axi_awaddr); end
        if (axi_wdata !== 16'h0ABC)   begin errors++; $display("FAIL single_wdata: got %h want 0abc", axi_wdata); end
        @(negedge axi_clk);                                                  // T+3 RESP
        set_pix(0, 0, 0, 12'h123);
        gfx_valid = 3'b001;
        #1; checks += 2;
        if (axi_awvalid !== 1'b0 || axi_bready !== 1'b1)
                                  begin errors++; $display("FAIL single_resp_T3: got aw=%b bready=%b want 0/1", axi_awvalid, axi_bready); end
        if (gfx_ready !== 3'b000) begin errors++; $display("FAIL single_ready_T3: got %b want 000", gfx_ready); end
        @(negedge axi_clk); #1;                                              // T+4 IDLE
        checks += 2;
        if (axi_bready !== 1'b0 || busy !== 1'b0)
                                  begin errors++; $display("FAIL single_idle_T4: got bready=%b busy=%b want 0/0", axi_bready, busy); end
        if (gfx_ready !== 3'b001) begin errors++; $display("FAIL single_ready_T4: got %b want 001", gfx_ready); end
        @(negedge axi_clk); gfx_valid = 3'b000;
        wait_idle();
        checks += 2;
        if (aw_log.size() !== 2)  begin errors++; $display("FAIL single_write_count: got %0d want 2", aw_log.size()); end
        else if (aw_log[0] !== 20'h01505 || w_log[0] !== 16'h0ABC || aw_log[1] !== 20'h01000 || w_log[1] !== 16'h0123)
            begin errors++; $display("FAIL single_write_log: got %h/%h %h/%h want 01505/0abc 01000/0123",
                                     aw_log[0], w_log[0], aw_log[1], w_log[1]); end
        else if (1'b1) ;
    endtask

    task automatic test_round_robin();
        automatic int          exp_ch;
        automatic logic [19:0] exp_addr;
        automatic bit          done = 0;
        do_reset();
        grant_log.delete(); aw_log.delete(); w_log.delete(); multi_ready = 0;
        @(negedge axi_clk);
        for (int c = 0; c < NUM_CH; c++) set_pix(c, 10 + c, c, 12'h100 + c);
        gfx_valid = 3'b111;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge axi_clk);
            if (grant_log.size() >= 9) done = 1;
        end
        gfx_valid = 3'b000;
        checks++;
        if (!done) begin errors++; $display("FAIL rr_timeout: got %0d grants want 9", grant_log.size()); end
        wait_idle();
        checks += 2;
        if (grant_log.size() !== 9) begin errors++; $display("FAIL rr_grant_count: got %0d want 9", grant_log.size()); end
        if (aw_log.size() !== 9)    begin errors++; $display("FAIL rr_write_count: got %0d want 9", aw_log.size()); end
        if (grant_log.size() == 9 && aw_log.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                exp_ch   = k % 3;
                exp_addr = (exp_ch == 0) ? 20'd4106 : (exp_ch == 1) ? 20'd4747 : 20'd5388;
                checks += 2;
                if (grant_log[k] !== exp_ch)
                    begin errors++; $display("FAIL rr_grant[%0d]: got %0d want %0d", k, grant_log[k], exp_ch); end
                if (aw_log[k] !== exp_addr)
                    begin errors++; $display("FAIL rr_addr[%0d]: got %h want %h", k, aw_log[k], exp_addr); end
            end
        end
        checks++;
        if (multi_ready !== 0) begin errors++; $display("FAIL rr_ready_onehot: got %0d multi-ready cycles want 0", multi_ready); end
    endtask

    task automatic test_clipping();
        automatic int aw_before;
        aw_before = awvalid_cycles;
        send_pixel(1, 640, 0, 12'h111);                                      // returns in CALC
        #1; checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clip_busy_calc: got %b want 1", busy); end
        @(negedge axi_clk); #1; checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clip_two_cycles: busy got %b want 0", busy); end
        send_pixel(1, 0, 480, 12'h222);
        wait_idle();
        checks += 2;
        if (dropped_count !== 16'd2)       begin errors++; $display("FAIL clip_dropped: got %0d want 2", dropped_count); end
        if (awvalid_cycles !== aw_before)  begin errors++; $display("FAIL clip_no_aw: got %0d awvalid cycles want 0", awvalid_cycles - aw_before); end
        send_pixel(1, 639, 479, 12'h333);
        wait_idle();
        checks += 2;
        if (aw_log.size() == 0 || aw_log[aw_log.size()-1] !== 20'h4BFFF)
            begin errors++; $display("FAIL clip_corner_addr: got %h want 4bfff", (aw_log.size() == 0) ? 20'h0 : aw_log[aw_log.size()-1]); end
        if (dropped_count !== 16'd2) begin errors++; $display("FAIL clip_corner_no_drop: got %0d want 2", dropped_count); end
    endtask

    task automatic test_saturation();
        @(negedge axi_clk);
        force dut.r_dropped_count = 16'hFFFE;
        @(negedge axi_clk);
        release dut.r_dropped_count;
        #1; checks++;
        if (dropped_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", dropped_count); end
        send_pixel(2, 700, 10, 12'h001);
        wait_idle();
        checks++;
        if (dropped_count !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %h want ffff", dropped_count); end
        send_pixel(2, 5, 500, 12'h002);
        send_pixel(2, 1023, 511, 12'h003);
        wait_idle();
        checks++;
        if (dropped_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", dropped_count); end
    endtask

    task automatic test_split_handshake();
        @(negedge axi_clk);
        axi_awready = 1'b0;
        send_pixel(2, 1, 1, 12'hFFF);                                        // T+1
        @(negedge axi_clk); #1; checks++;                                    // T+2
        if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b1)
            begin errors++; $display("FAIL split_entry: got aw=%b w=%b want 1/1", axi_awvalid, axi_wvalid); end
        for (int k = 3; k <= 6; k++) begin
            @(negedge axi_clk); #1; checks++;
            if (axi_awvalid !== 1'b1 || axi_wvalid !== 1'b0 || axi_awaddr !== 20'h01281 || axi_bready !== 1'b0)
                begin errors++; $display("FAIL split_hold_T%0d: got aw=%b w=%b addr=%h bready=%b want 1/0/01281/0",
                                         k, axi_awvalid, axi_wvalid, axi_awaddr, axi_bready); end
        end
        @(negedge axi_clk);                                                  // T+7
        axi_awready = 1'b1;
        #1; checks++;
        if (axi_awvalid !== 1'b1 || axi_bready !== 1'b0)
            begin errors++; $display("FAIL split_T7: got aw=%b bready=%b want 1/0", axi_awvalid, axi_bready); end
        @(negedge axi_clk); #1; checks++;                                    // T+8 RESP
        if (axi_awvalid !== 1'b0 || axi_bready !== 1'b1)
            begin errors++; $display("FAIL split_resp: got aw=%b bready=%b want 0/1", axi_awvalid, axi_bready); end
        wait_idle();
        checks++;
        if (aw_log.size() == 0 || aw_log[aw_log.size()-1] !== 20'h01281)
            begin errors++; $display("FAIL split_logged_addr: got %h want 01281", (aw_log.size() == 0) ? 20'h0 : aw_log[aw_log.size()-1]); end
    endtask

    task automatic test_error_resp();
        checks++;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", wr_err); end
        slave_bresp = 2'b10;
        send_pixel(0, 3, 3, 12'h0AA);
        wait_idle();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", wr_err); end
        slave_bresp = 2'b00;
        send_pixel(1, 4, 4, 12'h0BB);
        wait_idle();
        checks++;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", wr_err); end
    endtask

    task automatic test_reset_mid();
        @(negedge axi_clk);
        axi_awready = 1'b0;
        send_pixel(0, 7, 7, 12'h777);                                        // T+1, rr_ptr now 1
        @(negedge axi_clk); #1; checks++;                                    // T+2 WRITE
        if (axi_awvalid !== 1'b1) begin errors++; $display("FAIL rstmid_in_write: got %b want 1", axi_awvalid); end
        @(negedge axi_clk);
        axi_resetn = 1'b0;
        gfx_valid  = 3'b111;
        #1; checks += 3;
        if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs: got aw=%b w=%b busy=%b want 0/0/0", axi_awvalid, axi_wvalid, busy); end
        if (gfx_ready !== 3'b000) begin errors++; $display("FAIL rstmid_ready: got %b want 000", gfx_ready); end
        if (wr_err !== 1'b0 || dropped_count !== 16'h0)
            begin errors++; $display("FAIL rstmid_status: got err=%b dropped=%h want 0/0", wr_err, dropped_count); end
        @(negedge axi_clk);
        grant_log.delete();
        axi_resetn  = 1'b1;
        axi_awready = 1'b1;
        #1; checks++;
        if (gfx_ready !== 3'b001) begin errors++; $display("FAIL rstmid_first_ready: got %b want 001", gfx_ready); end
        @(negedge axi_clk);
        gfx_valid = 3'b000;
        checks++;
        if (grant_log.size() !== 1 || grant_log[0] !== 0)
            begin errors++; $display("FAIL rstmid_first_grant: got %0d grants first=%0d want 1 grant to ch0",
                                     grant_log.size(), (grant_log.size() == 0) ? -1 : grant_log[0]); end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_clipping();
        test_saturation();
        test_split_handshake();
        test_error_resp();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
